// File: rtl/shift_add_multiplier_16bit_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package shift_add_multiplier_16bit_pkg;

    localparam int MUL_OP_W   = 16;
    localparam int MUL_PROD_W = 32;
    localparam int MUL_CNT_W  = 5;

    // Last iteration index: the edge that performs iteration 16 sees cnt == 15.
    localparam logic [MUL_CNT_W-1:0] MUL_LAST_ITER = MUL_CNT_W'(MUL_OP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage : shift_add_multiplier_16bit_pkg

// File: rtl/shift_add_multiplier_16bit_adder.sv
// 16-bit ripple-carry adder built from a chain of one-bit full-adder cells.
module full_adder_16bit
    import shift_add_multiplier_16bit_pkg::*;
(
    input  logic [MUL_OP_W-1:0] i_a,
    input  logic [MUL_OP_W-1:0] i_b,
    input  logic                i_cin,
    output logic [MUL_OP_W-1:0] o_sum,
    output logic                o_cout
);

    logic [MUL_OP_W:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    generate
        for (genvar gi = 0; gi < MUL_OP_W; gi++) begin : g_bit
            logic w_prop;
            assign w_prop          = i_a[gi] ^ i_b[gi];
            assign o_sum[gi]       = w_prop ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_prop & w_carry[gi]);
        end
    endgenerate

    assign o_cout = w_carry[MUL_OP_W];

endmodule : full_adder_16bit

// File: rtl/shift_add_multiplier_16bit.sv
// Sequential 16x16 unsigned multiplier: one shift-and-add step per clock,
// using the ripple-carry adder as its only arithmetic datapath.
module shift_add_multiplier_16bit
    import shift_add_multiplier_16bit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MUL_OP_W-1:0]   a,
    input  logic [MUL_OP_W-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [MUL_PROD_W-1:0] product
);

    mul_state_t             r_state;
    mul_state_t             w_state_next;
    logic [MUL_OP_W-1:0]    r_a;
    logic [MUL_PROD_W-1:0]  r_p;
    logic [MUL_CNT_W-1:0]   r_cnt;

    logic                   w_accept;
    logic [MUL_OP_W-1:0]    w_addend;
    logic [MUL_OP_W-1:0]    w_sum;
    logic                   w_cout;

    // A start only counts when the controller finds us idle.
    assign w_accept = (r_state == IDLE) && start;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign w_addend = r_p[0] ? r_a : '0;

    full_adder_16bit u_adder (
        .i_a    (r_p[MUL_PROD_W-1:MUL_OP_W]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after 16 steps, DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == MUL_LAST_ITER) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load operands on accept, then shift the adder result into P.
    // The carry-out lands in P[31] so the full 32-bit product is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_p   <= {{MUL_OP_W{1'b0}}, b};
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_p   <= {w_cout, w_sum, r_p[MUL_OP_W-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_p;

endmodule : shift_add_multiplier_16bit

// File: tb/tb_shift_add_multiplier_16bit.sv
// Self-checking bench: randomized and directed operands compared against
// a cycle-level behavioural model that computes the product with plain '*'.
module tb_shift_add_multiplier_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 running, 2 done pulse.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_exp   = 32'h0;
    bit          m_valid = 1'b1;
    logic [15:0] m_a     = 16'h0;
    logic [15:0] m_b     = 16'h0;
    int          n_done  = 0;

    shift_add_multiplier_16bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare outputs on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0;
            m_exp   = 32'h0;
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_a     = a;
                    m_b     = b;
                    m_exp   = 32'(a) * 32'(b);
                    m_valid = 1'b0;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        @(negedge clk);
        check_val({tag, " busy"}, 32'(busy), 32'(m_phase == 1));
        check_val({tag, " done"}, 32'(done), 32'(m_phase == 2));
        if (m_valid) check_val({tag, " product"}, product, m_exp);
        if (m_phase == 2) begin
            n_done++;
            $display("[TB] %s: 0x%04h * 0x%04h -> 0x%08h (model 0x%08h)",
                     tag, m_a, m_b, product, m_exp);
        end
    endtask

    // One isolated operation; operands are scrambled during RUN.
    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        step(tag);
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            step(tag);
        end
    endtask

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int          done_before;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;

        // Reset state
        step("reset");
        step("reset");
        rst_n = 1'b1;
        step("idle");

        // Directed cases
        run_op("3x5",        16'h0003, 16'h0005);
        run_op("ffff_sq",    16'hFFFF, 16'hFFFF);
        run_op("1234x5678",  16'h1234, 16'h5678);
        run_op("zero_a",     16'h0000, 16'h1234);
        run_op("zero_b",     16'hABCD, 16'h0000);

        // Random cases
        for (int i = 0; i < 20; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom));
        end

        // Back-to-back with start held high; operands change mid-RUN
        q_a = '{16'h0007, 16'hFFFF, 16'h8001, 16'($urandom)};
        q_b = '{16'h0009, 16'h0002, 16'hFFFF, 16'($urandom)};
        done_before = n_done;
        start = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (m_phase == 0 && start) begin
                if (q_a.size() > 0) begin
                    a = q_a.pop_front();
                    b = q_b.pop_front();
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = (i % 2 == 0) ? 16'hFFFF : 16'($urandom);
                b = (i % 2 == 0) ? 16'hFFFF : 16'($urandom);
            end
            step("b2b");
        end
        start = 1'b0;
        check_val("b2b done count", 32'(n_done - done_before), 32'd4);

        // Reset during iteration 8
        a     = 16'h00FF;
        b     = 16'h0101;
        start = 1'b1;
        step("abort");
        start = 1'b0;
        for (int i = 0; i < 7; i++) step("abort");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async rst busy",    32'(busy), 32'd0);
        check_val("async rst done",    32'(done), 32'd0);
        check_val("async rst product", product,   32'h0);
        $display("[TB] reset asserted mid-run, outputs cleared");
        done_before = n_done;
        step("in_reset");
        step("in_reset");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("post_reset");
        check_val("aborted op no done", 32'(n_done - done_before), 32'd0);
        run_op("after_abort", 16'h00FF, 16'h0101);
        check_val("after_abort product", product, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_add_multiplier_16bit
